// File: rtl/frec_conmu_param_if.sv
// Button/select inputs and divided-clock/index outputs of the frequency modifier.
interface frec_conmu_param_if #(
  parameter int IDX_W = 4
);
  logic             aumentar;
  logic             disminuir;
  logic             chip_select;
  logic             clk_dividido;
  logic             tick_1k;
  logic [IDX_W-1:0] idx;
  logic             idx_changed;

  modport master (
    output aumentar, disminuir, chip_select,
    input  clk_dividido, tick_1k, idx, idx_changed
  );

  modport slave (
    input  aumentar, disminuir, chip_select,
    output clk_dividido, tick_1k, idx, idx_changed
  );
endinterface

// File: rtl/frec_conmu_param.sv
// Switching-frequency modifier: debounced up/down buttons step a frequency index,
// which sets the half-period of a glitch-free divided clock; plus a fixed-rate tick.
module frec_conmu_param #(
  parameter int IDX_W     = 4,
  parameter int N_STEPS   = 16,
  parameter int WRAP      = 0,
  parameter int DEB_CYC   = 1_000_000,
  parameter int HALF_MAX  = 50_000,
  parameter int HALF_STEP = 3_000,
  parameter int CNT_W     = 17,
  parameter int TICK_DIV  = 100_000
) (
  input  logic                clk,
  input  logic                reset,
  frec_conmu_param_if.slave   bus
);

  localparam int               DW      = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);
  localparam int               PW      = CNT_W + IDX_W + 2;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_STEPS - 1);
  localparam int               H0      = (HALF_MAX < 2) ? 2 : HALF_MAX;

  // bit 0 = up button, bit 1 = down button
  logic [1:0]          w_btn;
  logic [1:0]          r_sync1, r_sync2;
  logic [1:0]          r_acc, r_acc_d;
  logic [1:0][DW-1:0]  r_deb_cnt;
  logic [1:0]          w_ev;

  logic [IDX_W-1:0]    r_idx;
  logic                r_idx_chg;

  logic signed [PW-1:0] w_h_full;
  logic [CNT_W-1:0]     w_half;
  logic [CNT_W-1:0]     r_half_m1;
  logic [CNT_W-1:0]     r_div_cnt;
  logic                 r_clk_div;

  logic [CNT_W-1:0]     r_tick_cnt;
  logic [CNT_W-1:0]     w_tick_nxt;
  logic                 r_tick;

  assign w_btn = {bus.disminuir, bus.aumentar};

  // Two-stage synchroniser, then accept a level only after DEB_CYC consecutive differing cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_acc     <= '0;
      r_acc_d   <= '0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_acc_d <= r_acc;
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] != r_acc[b]) begin
          if (r_deb_cnt[b] == DW'(DEB_CYC - 1)) begin
            r_acc[b]     <= r_sync2[b];
            r_deb_cnt[b] <= '0;
          end else begin
            r_deb_cnt[b] <= r_deb_cnt[b] + DW'(1);
          end
        end else begin
          r_deb_cnt[b] <= '0;
        end
      end
    end
  end

  // Press events exist only on accepted rising edges while the block is selected.
  assign w_ev = r_acc & ~r_acc_d & {2{bus.chip_select}};

  // Step the index; simultaneous up/down cancels, saturated requests produce no change pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx     <= '0;
      r_idx_chg <= 1'b0;
    end else begin
      r_idx_chg <= 1'b0;
      if (w_ev[0] && !w_ev[1]) begin
        if (r_idx == IDX_MAX) begin
          if (WRAP != 0 && IDX_MAX != '0) begin
            r_idx     <= '0;
            r_idx_chg <= 1'b1;
          end
        end else begin
          r_idx     <= r_idx + IDX_W'(1);
          r_idx_chg <= 1'b1;
        end
      end else if (w_ev[1] && !w_ev[0]) begin
        if (r_idx == '0) begin
          if (WRAP != 0 && IDX_MAX != '0) begin
            r_idx     <= IDX_MAX;
            r_idx_chg <= 1'b1;
          end
        end else begin
          r_idx     <= r_idx - IDX_W'(1);
          r_idx_chg <= 1'b1;
        end
      end
    end
  end

  // Half-period from the index, computed wide and signed so large indices clamp instead of wrapping.
  always_comb begin
    w_half   = CNT_W'(2);
    w_h_full = $signed(PW'(HALF_MAX)) - $signed(PW'(r_idx)) * $signed(PW'(HALF_STEP));
    if (w_h_full >= $signed(PW'(2)))
      w_half = w_h_full[CNT_W-1:0];
  end

  // Divider: the half-period is latched only on a toggle, so index changes never cut a half-period short.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt <= '0;
      r_clk_div <= 1'b0;
      r_half_m1 <= CNT_W'(H0 - 1);
    end else if (r_div_cnt == r_half_m1) begin
      r_div_cnt <= '0;
      r_clk_div <= ~r_clk_div;
      r_half_m1 <= w_half - CNT_W'(1);
    end else begin
      r_div_cnt <= r_div_cnt + CNT_W'(1);
    end
  end

  assign w_tick_nxt = (r_tick_cnt == CNT_W'(TICK_DIV - 1)) ? '0 : r_tick_cnt + CNT_W'(1);

  // Free-running tick; the pulse register tracks the cycle the count sits at its terminal value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick_nxt;
      r_tick     <= (w_tick_nxt == CNT_W'(TICK_DIV - 1));
    end
  end

  assign bus.clk_dividido = r_clk_div;
  assign bus.tick_1k      = r_tick;
  assign bus.idx          = r_idx;
  assign bus.idx_changed  = r_idx_chg;

endmodule

// File: tb/tb_frec_conmu_param.sv
// Bench for frec_conmu_param: a saturating and a wrapping instance, directed presses,
// index-change scoreboard per instance, divider/tick timing checks.
module tb_frec_conmu_param;
  localparam int IDX_W     = 4;
  localparam int N_STEPS   = 4;
  localparam int DEB_CYC   = 4;
  localparam int HALF_MAX  = 10;
  localparam int HALF_STEP = 2;
  localparam int CNT_W     = 8;
  localparam int TICK_DIV  = 8;

  logic clk = 1'b0;
  logic rst_s, rst_w;
  int   checks = 0;
  int   errors = 0;

  logic [IDX_W-1:0] q_s[$];
  logic [IDX_W-1:0] q_w[$];

  int   last_tog, last_tick, n_tog, n_tick, t_idx, n_wait;
  logic prev;
  int   tog [4];

  frec_conmu_param_if #(.IDX_W(IDX_W)) bs ();
  frec_conmu_param_if #(.IDX_W(IDX_W)) bw ();

  frec_conmu_param #(
    .IDX_W(IDX_W), .N_STEPS(N_STEPS), .WRAP(0), .DEB_CYC(DEB_CYC), .HALF_MAX(HALF_MAX),
    .HALF_STEP(HALF_STEP), .CNT_W(CNT_W), .TICK_DIV(TICK_DIV)
  ) u_sat (.clk(clk), .reset(rst_s), .bus(bs));

  frec_conmu_param #(
    .IDX_W(IDX_W), .N_STEPS(N_STEPS), .WRAP(1), .DEB_CYC(DEB_CYC), .HALF_MAX(HALF_MAX),
    .HALF_STEP(HALF_STEP), .CNT_W(CNT_W), .TICK_DIV(TICK_DIV)
  ) u_wrap (.clk(clk), .reset(rst_w), .bus(bw));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_btn(input bit w, input logic up, input logic dn, input logic cs);
    if (w) begin
      bw.aumentar = up; bw.disminuir = dn; bw.chip_select = cs;
    end else begin
      bs.aumentar = up; bs.disminuir = dn; bs.chip_select = cs;
    end
  endtask

  // One clean press: hold long enough to be accepted, release, let the release settle.
  task automatic press(input bit w, input logic up, input logic dn, input logic cs,
                       input logic [IDX_W-1:0] exp, input bit chg, input string name);
    @(negedge clk);
    if (chg) begin
      if (w) q_w.push_back(exp);
      else   q_s.push_back(exp);
    end
    set_btn(w, up, dn, cs);
    repeat (9) @(negedge clk);
    set_btn(w, 1'b0, 1'b0, cs);
    repeat (8) @(negedge clk);
    set_btn(w, 1'b0, 1'b0, 1'b1);
    check(name, w ? 32'(bw.idx) : 32'(bs.idx), 32'(exp));
  endtask

  // Scoreboard monitors: every idx_changed pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bs.idx_changed === 1'b1) begin
      if (q_s.size() == 0) begin
        checks++; errors++;
        $display("FAIL sat_unexpected_change: got change to idx %0d expected no change", bs.idx);
      end else begin
        check("sat_change_idx", 32'(bs.idx), 32'(q_s.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (bw.idx_changed === 1'b1) begin
      if (q_w.size() == 0) begin
        checks++; errors++;
        $display("FAIL wrap_unexpected_change: got change to idx %0d expected no change", bw.idx);
      end else begin
        check("wrap_change_idx", 32'(bw.idx), 32'(q_w.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_s = 1'b1; rst_w = 1'b1;
    set_btn(1'b0, 1'b0, 1'b0, 1'b1);
    set_btn(1'b1, 1'b0, 1'b0, 1'b1);
    #2 rst_s = 1'b0; rst_w = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_idx_s",     32'(bs.idx), 0);
    check("rst_clkdiv_s",  32'(bs.clk_dividido), 0);
    check("rst_tick_s",    32'(bs.tick_1k), 0);
    check("rst_chg_s",     32'(bs.idx_changed), 0);
    check("rst_idx_w",     32'(bw.idx), 0);
    check("rst_clkdiv_w",  32'(bw.clk_dividido), 0);

    // T1: idle timing
    rst_s = 1'b1; rst_w = 1'b1;
    last_tog = 0; last_tick = 0; n_tog = 0; n_tick = 0; prev = 1'b0;
    for (int k = 1; k <= 41; k++) begin
      @(posedge clk); #1;
      if (bs.clk_dividido !== prev) begin
        check("t1_toggle_spacing", k - last_tog, 10);
        last_tog = k; n_tog++; prev = bs.clk_dividido;
      end
      if (bs.tick_1k === 1'b1) begin
        if (n_tick > 0) check("t1_tick_spacing", k - last_tick, 8);
        last_tick = k; n_tick++;
      end
    end
    check("t1_toggle_count", n_tog, 4);
    check("t1_tick_count", n_tick, 5);
    check("t1_idx_idle", 32'(bs.idx), 0);

    // T2: bounce then a held level
    @(negedge clk); bs.aumentar = 1'b1;
    @(negedge clk); bs.aumentar = 1'b0;
    @(negedge clk); bs.aumentar = 1'b1;
    @(negedge clk); bs.aumentar = 1'b0;
    @(negedge clk); bs.aumentar = 1'b1; q_s.push_back(4'd1);
    t_idx = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (bs.idx === 4'd1 && t_idx == 0) t_idx = k;
      if (k == 6) begin
        @(negedge clk); bs.aumentar = 1'b0;
      end
    end
    check("t2_latency", t_idx, 7);
    repeat (8) @(negedge clk);
    check("t2_idx", 32'(bs.idx), 1);

    @(negedge clk); rst_s = 1'b0;
    @(negedge clk);
    check("rst2_idx_s", 32'(bs.idx), 0);
    rst_s = 1'b1;

    // T3: saturation
    press(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, "t3_up1");
    press(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b1, "t3_up2");
    press(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, "t3_up3");
    press(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, "t3_up4_sat");
    press(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, "t3_up5_sat");
    press(1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b1, "t3_dn1");
    press(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, "t3_dn2");
    press(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, "t3_dn3");
    press(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, "t3_dn4_sat");

    // T5: simultaneous and masked presses
    press(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, "t5_up");
    press(1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, "t5_both");
    press(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, "t5_masked");

    // T4: wrap
    press(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, "t4_up1");
    press(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 1'b1, "t4_up2");
    press(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, "t4_up3");
    press(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, "t4_up_wrap");
    press(1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, "t4_dn_wrap");

    // T6: async reset mid-count, then an index change mid half-period
    n_wait = 0;
    while (bw.clk_dividido !== 1'b1 && n_wait < 30) begin
      @(posedge clk); #1; n_wait++;
    end
    check("t6_wait_high", 32'(bw.clk_dividido), 1);
    #2 rst_w = 1'b0;
    #1;
    check("t6_async_rst_clkdiv", 32'(bw.clk_dividido), 0);
    check("t6_async_rst_idx", 32'(bw.idx), 0);
    @(negedge clk); @(negedge clk);
    rst_w = 1'b1;
    bw.disminuir = 1'b1;
    q_w.push_back(4'd3);
    prev = 1'b0; n_tog = 0; t_idx = 0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (bw.clk_dividido !== prev) begin
        if (n_tog < 4) tog[n_tog] = k;
        n_tog++; prev = bw.clk_dividido;
      end
      if (bw.idx === 4'd3 && t_idx == 0) t_idx = k;
      if (k == 8) begin
        @(negedge clk); bw.disminuir = 1'b0;
      end
    end
    check("t6_idx_change_cycle", t_idx, 7);
    check("t6_toggle_count", n_tog, 4);
    check("t6_toggle0", tog[0], 10);
    check("t6_toggle1", tog[1], 14);
    check("t6_toggle2", tog[2], 18);
    check("t6_toggle3", tog[3], 22);

    repeat (10) @(negedge clk);
    check("sat_pending_changes", q_s.size(), 0);
    check("wrap_pending_changes", q_w.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
